// File: rtl/seq_detector_param_if.sv
// Bus bundle for the serial pattern detector: configuration inputs,
// the qualified serial stream, and the match/status outputs.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);

  logic               cfg_load;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               in_valid;
  logic               din;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  // Stream/config source (testbench or upstream block)
  modport master (
    output cfg_load,
    output pat,
    output pat_len,
    output overlap,
    output in_valid,
    output din,
    input  out,
    input  match_cnt,
    input  cfg_err
  );

  // Detector side
  modport slave (
    input  cfg_load,
    input  pat,
    input  pat_len,
    input  overlap,
    input  in_valid,
    input  din,
    output out,
    output match_cnt,
    output cfg_err
  );

endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Moore output).
// The pattern is 1..MAX_LEN bits long, loaded through cfg_load, and may be
// matched in overlapping or non-overlapping mode. Bits are only consumed
// when in_valid is high; idle cycles are transparent to matching. A
// saturating counter tracks matches since reset or the last cfg_load.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input logic                clk,
  input logic                rst,
  seq_detector_param_if.slave bus
);

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Mask selecting the low 'len' bits of the history/pattern compare
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // A length of zero or beyond the history depth cannot be matched
  function automatic logic len_bad(input logic [LEN_W-1:0] len);
    logic bad;
    if ((len == {LEN_W{1'b0}}) || (int'(len) > MAX_LEN)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // Fill counter increment that saturates at the history depth
  function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] fill);
    logic [LEN_W-1:0] f;
    if (fill >= LEN_W'(MAX_LEN)) begin
      f = LEN_W'(MAX_LEN);
    end else begin
      f = fill + LEN_W'(1);
    end
    return f;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------

  // Latched configuration
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic               cfg_err_r;

  // Received-bit history. Only MAX_LEN-1 bits need to be stored: the
  // compare window is formed from these plus the incoming bit, so the
  // oldest stored bit would always be shifted out before it is examined.
  logic [MAX_LEN-2:0] hist_r;
  logic [LEN_W-1:0]   fill_r;

  // Registered outputs
  logic               out_r;
  logic [CNT_W-1:0]   cnt_r;

  // Combinational next-state terms
  logic               active_s;
  logic [MAX_LEN-1:0] hist_n_s;
  logic [LEN_W-1:0]   fill_n_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               match_s;
  logic               hit_s;
  logic               cnt_sat_s;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Candidate history/fill for this bit and the match decision
  always_comb begin
    active_s  = 1'b0;
    hist_n_s  = {hist_r, bus.din};
    fill_n_s  = fill_inc(fill_r);
    mask_s    = len_mask(len_r);
    match_s   = 1'b0;
    hit_s     = 1'b0;
    cnt_sat_s = 1'b0;

    // cfg_load wins over a same-cycle data bit; a bad config ignores data
    if (bus.in_valid && !bus.cfg_load && !cfg_err_r) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end

    // Only the low len bits take part in the compare
    if (((hist_n_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}}) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end

    // A hit also requires len bits received since the last clear
    if (active_s && (fill_n_s >= len_r) && match_s) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end

    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_sat_s = 1'b1;
    end else begin
      cnt_sat_s = 1'b0;
    end
  end

  // Configuration capture and validity flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r     <= {MAX_LEN{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      ovl_r     <= 1'b0;
      cfg_err_r <= 1'b1;
    end else if (bus.cfg_load) begin
      pat_r     <= bus.pat;
      len_r     <= bus.pat_len;
      ovl_r     <= bus.overlap;
      cfg_err_r <= len_bad(bus.pat_len);
    end
  end

  // History shift register and fill count; non-overlap mode restarts after a hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {LEN_W{1'b0}};
    end else if (bus.cfg_load) begin
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {LEN_W{1'b0}};
    end else if (active_s) begin
      if (hit_s && !ovl_r) begin
        hist_r <= {(MAX_LEN-1){1'b0}};
        fill_r <= {LEN_W{1'b0}};
      end else begin
        hist_r <= hist_n_s[MAX_LEN-2:0];
        fill_r <= fill_n_s;
      end
    end
  end

  // One-cycle match pulse and saturating match counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (bus.cfg_load) begin
      out_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      out_r <= hit_s;
      if (hit_s && !cnt_sat_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.match_cnt = cnt_r;
  assign bus.cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: one DUT with default widths and a
// second with a 2-bit counter to reach saturation quickly.
module tb_seq_detector_param;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) if_a ();
  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) if_b ();

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  // Free-running clock, 10 time units
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One data cycle on DUT A; outputs settled #1 after the sampling edge
  task automatic step_a(input logic v, input logic d);
    if_a.in_valid = v;
    if_a.din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic d);
    if_b.in_valid = v;
    if_b.din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] p, input logic [3:0] l, input logic o);
    if_a.cfg_load = 1'b1;
    if_a.pat      = p;
    if_a.pat_len  = l;
    if_a.overlap  = o;
    if_a.in_valid = 1'b0;
    @(posedge clk);
    #1;
    if_a.cfg_load = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic v, input logic d);
    if_b.cfg_load = 1'b1;
    if_b.pat      = p;
    if_b.pat_len  = l;
    if_b.overlap  = o;
    if_b.in_valid = v;
    if_b.din      = d;
    @(posedge clk);
    #1;
    if_b.cfg_load = 1'b0;
    if_b.in_valid = 1'b0;
    if_b.din      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (if_a.out !== 1'b0) begin
      n_bad++; $display("FAIL reset_out: got %b want 0", if_a.out);
    end
    n_cmp++;
    if (if_a.match_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", if_a.match_cnt);
    end
    n_cmp++;
    if (if_a.cfg_err !== 1'b1) begin
      n_bad++; $display("FAIL reset_cfg_err: got %b want 1", if_a.cfg_err);
    end
    rst = 1'b0;
  endtask

  // No configuration loaded: stream 1010 must be ignored
  task automatic test_no_cfg();
    logic [3:0] bits;
    bits = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      step_a(1'b1, bits[i]);
      n_cmp++;
      if (if_a.out !== 1'b0) begin
        n_bad++; $display("FAIL no_cfg_out bit%0d: got %b want 0", 4 - i, if_a.out);
      end
    end
    n_cmp++;
    if (if_a.match_cnt !== 8'd0 || if_a.cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL no_cfg_state: got cnt=%0d err=%b want cnt=0 err=1", if_a.match_cnt, if_a.cfg_err);
    end
  endtask

  task automatic test_nonoverlap();
    logic [9:0] bits;
    logic [9:0] exp;
    bits = 10'b1010101010;
    exp  = 10'b0001000100;
    load_a(8'b00001010, 4'd4, 1'b0);
    n_cmp++;
    if (if_a.cfg_err !== 1'b0) begin
      n_bad++; $display("FAIL nonovl_cfg_err: got %b want 0", if_a.cfg_err);
    end
    for (int i = 9; i >= 0; i--) begin
      step_a(1'b1, bits[i]);
      n_cmp++;
      if (if_a.out !== exp[i]) begin
        n_bad++; $display("FAIL nonovl_out bit%0d: got %b want %b", 10 - i, if_a.out, exp[i]);
      end
    end
    n_cmp++;
    if (if_a.match_cnt !== 8'd2) begin
      n_bad++; $display("FAIL nonovl_cnt: got %0d want 2", if_a.match_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [9:0] bits;
    logic [9:0] exp;
    bits = 10'b1010101010;
    exp  = 10'b0001010101;
    load_a(8'b00001010, 4'd4, 1'b1);
    n_cmp++;
    if (if_a.match_cnt !== 8'd0) begin
      n_bad++; $display("FAIL ovl_cnt_clear: got %0d want 0", if_a.match_cnt);
    end
    for (int i = 9; i >= 0; i--) begin
      step_a(1'b1, bits[i]);
      n_cmp++;
      if (if_a.out !== exp[i]) begin
        n_bad++; $display("FAIL ovl_out bit%0d: got %b want %b", 10 - i, if_a.out, exp[i]);
      end
    end
    n_cmp++;
    if (if_a.match_cnt !== 8'd4) begin
      n_bad++; $display("FAIL ovl_cnt: got %0d want 4", if_a.match_cnt);
    end
  endtask

  // Idle cycles between valid bits are transparent
  task automatic test_gap();
    logic [6:0] v;
    logic [6:0] d;
    logic [6:0] exp;
    v   = 7'b1100011;
    d   = 7'b1000010;
    exp = 7'b0000001;
    load_a(8'b00001010, 4'd4, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      step_a(v[i], d[i]);
      n_cmp++;
      if (if_a.out !== exp[i]) begin
        n_bad++; $display("FAIL gap_out cyc%0d: got %b want %b", 7 - i, if_a.out, exp[i]);
      end
    end
    step_a(1'b0, 1'b0);
    n_cmp++;
    if (if_a.out !== 1'b0 || if_a.match_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL gap_after: got out=%b cnt=%0d want out=0 cnt=1", if_a.out, if_a.match_cnt);
    end
  endtask

  // Single-bit pattern: each matching bit hits
  task automatic test_len1();
    logic [3:0] bits;
    logic [3:0] exp;
    bits = 4'b1101;
    exp  = 4'b1101;
    load_a(8'b00000001, 4'd1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      step_a(1'b1, bits[i]);
      n_cmp++;
      if (if_a.out !== exp[i]) begin
        n_bad++; $display("FAIL len1_out bit%0d: got %b want %b", 4 - i, if_a.out, exp[i]);
      end
    end
    n_cmp++;
    if (if_a.match_cnt !== 8'd3) begin
      n_bad++; $display("FAIL len1_cnt: got %0d want 3", if_a.match_cnt);
    end
  endtask

  // Full-length pattern at the history depth
  task automatic test_len_max();
    logic [7:0] bits;
    logic [7:0] exp;
    bits = 8'b10100101;
    exp  = 8'b00000001;
    load_a(8'hA5, 4'd8, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      step_a(1'b1, bits[i]);
      n_cmp++;
      if (if_a.out !== exp[i]) begin
        n_bad++; $display("FAIL lenmax_out bit%0d: got %b want %b", 8 - i, if_a.out, exp[i]);
      end
    end
  endtask

  // 2-bit counter sticks at 3; cfg_load beats a same-cycle data bit
  task automatic test_saturate();
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    load_b(8'b00000001, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step_b(1'b1, 1'b1);
      n_cmp++;
      if (int'(if_b.match_cnt) != exp_cnt[i] || if_b.out !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_cnt bit%0d: got cnt=%0d out=%b want cnt=%0d out=1",
                 i + 1, if_b.match_cnt, if_b.out, exp_cnt[i]);
      end
    end
    load_b(8'b00000001, 4'd1, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (if_b.match_cnt !== 2'd0 || if_b.out !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_cfg_prio: got cnt=%0d out=%b want cnt=0 out=0", if_b.match_cnt, if_b.out);
    end
  endtask

  // Reset mid-pattern discards the partial match immediately
  task automatic test_rst_mid();
    logic [6:0] bits;
    bits = 7'b1010101;
    load_a(8'b00001010, 4'd4, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step_a(1'b1, bits[i]);
    end
    n_cmp++;
    if (if_a.match_cnt !== 8'd1) begin
      n_bad++; $display("FAIL rstmid_pre_cnt: got %0d want 1", if_a.match_cnt);
    end
    if_a.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    n_cmp++;
    if (if_a.match_cnt !== 8'd0 || if_a.cfg_err !== 1'b1 || if_a.out !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async: got cnt=%0d err=%b out=%b want cnt=0 err=1 out=0",
               if_a.match_cnt, if_a.cfg_err, if_a.out);
    end
    rst = 1'b0;
    step_a(1'b1, 1'b0);
    n_cmp++;
    if (if_a.out !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_no_cfg: got %b want 0", if_a.out);
    end
    load_a(8'b00001010, 4'd4, 1'b0);
    step_a(1'b1, 1'b0);
    n_cmp++;
    if (if_a.out !== 1'b0 || if_a.match_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL rstmid_lost: got out=%b cnt=%0d want out=0 cnt=0", if_a.out, if_a.match_cnt);
    end
  endtask

  // Out-of-range lengths flag an error and disable detection
  task automatic test_bad_len();
    load_a(8'b00001010, 4'd9, 1'b0);
    n_cmp++;
    if (if_a.cfg_err !== 1'b1) begin
      n_bad++; $display("FAIL badlen9_err: got %b want 1", if_a.cfg_err);
    end
    step_a(1'b1, 1'b0);
    n_cmp++;
    if (if_a.out !== 1'b0 || if_a.match_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL badlen9_idle: got out=%b cnt=%0d want out=0 cnt=0", if_a.out, if_a.match_cnt);
    end
    load_a(8'b00000001, 4'd1, 1'b0);
    n_cmp++;
    if (if_a.cfg_err !== 1'b0) begin
      n_bad++; $display("FAIL badlen_recover: got %b want 0", if_a.cfg_err);
    end
    load_a(8'b00000001, 4'd0, 1'b0);
    n_cmp++;
    if (if_a.cfg_err !== 1'b1) begin
      n_bad++; $display("FAIL badlen0_err: got %b want 1", if_a.cfg_err);
    end
    step_a(1'b1, 1'b1);
    n_cmp++;
    if (if_a.out !== 1'b0 || if_a.match_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL badlen0_idle: got out=%b cnt=%0d want out=0 cnt=0", if_a.out, if_a.match_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    if_a.cfg_load = 1'b0; if_a.pat = 8'd0; if_a.pat_len = 4'd0;
    if_a.overlap  = 1'b0; if_a.in_valid = 1'b0; if_a.din = 1'b0;
    if_b.cfg_load = 1'b0; if_b.pat = 8'd0; if_b.pat_len = 4'd0;
    if_b.overlap  = 1'b0; if_b.in_valid = 1'b0; if_b.din = 1'b0;

    test_reset();
    test_no_cfg();
    test_nonoverlap();
    test_overlap();
    test_gap();
    test_len1();
    test_len_max();
    test_saturate();
    test_rst_mid();
    test_bad_len();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
